// File: rtl/key_counter_ctrl.sv
// Front-panel controller: tick divider, 2-flop sync + tick-sampled debounce for
// three keys, priority arbitration and hold-to-repeat stepping of a shared counter.
module key_counter_ctrl #(
   parameter int unsigned DIV        = 5000,
   parameter int unsigned DEB_LEN    = 7,
   parameter int unsigned CNT_W      = 3,
   parameter int unsigned HOLD_TICKS = 500,
   parameter int unsigned REP_TICKS  = 100
) (
   input  logic             MHz,
   input  logic             rst_n,
   input  logic             key_up,
   input  logic             key_dn,
   input  logic             key_clr,
   output logic [CNT_W-1:0] counter,
   output logic             evt,
   output logic             led,
   output logic             tick
);

   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int unsigned REP_W  = $clog2(REP_TICKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_e;
   typedef enum logic [1:0] {K_UP, K_DN, K_CLR} key_e;

   logic [DIV_W-1:0]  div_q, div_d;
   logic [2:0]        sync1_q, sync2_q;
   logic [2:0]        deb;
   state_e            state_q, state_d;
   key_e              key_q, key_d, act_key;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              evt_q, evt_d;
   logic              act, held_lvl;

   assign tick  = (div_q == DIV_W'(DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;

   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         div_q   <= div_d;
         sync1_q <= {key_clr, key_dn, key_up};
         sync2_q <= sync1_q;
      end
   end

   // Bit order of deb: 0 = up, 1 = dn, 2 = clr
   for (genvar k = 0; k < 3; k++) begin : g_deb
      logic [DEB_LEN-1:0] sh_q, sh_d;
      logic               lvl_q, lvl_d;

      always_comb begin
         sh_d  = sh_q;
         lvl_d = lvl_q;
         if (tick) begin
            sh_d = {sh_q[DEB_LEN-2:0], sync2_q[k]};
            if (&sh_d)
               lvl_d = 1'b1;
            else if (~|sh_d)
               lvl_d = 1'b0;
         end
      end

      always_ff @(posedge MHz or negedge rst_n) begin
         if (!rst_n) begin
            sh_q  <= '0;
            lvl_q <= 1'b0;
         end else begin
            sh_q  <= sh_d;
            lvl_q <= lvl_d;
         end
      end

      assign deb[k] = lvl_q;
   end

   always_comb begin
      case (key_q)
         K_UP:    held_lvl = deb[0];
         K_DN:    held_lvl = deb[1];
         default: held_lvl = deb[2];
      endcase
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
      act     = 1'b0;
      act_key = key_q;
      case (state_q)
         S_IDLE: begin
            if (|deb) begin
               if (deb[2])      act_key = K_CLR;
               else if (deb[0]) act_key = K_UP;
               else             act_key = K_DN;
               key_d   = act_key;
               state_d = S_HELD;
               hold_d  = '0;
               rep_d   = '0;
               act     = 1'b1;
            end
         end
         S_HELD: begin
            if (!held_lvl) begin
               state_d = S_IDLE;
               hold_d  = '0;
               rep_d   = '0;
            end else if (tick && hold_q != HOLD_W'(HOLD_TICKS)) begin
               // clr saturates here instead of wrapping; it never repeats
               hold_d = hold_q + 1'b1;
               if (key_q != K_CLR && hold_d == HOLD_W'(HOLD_TICKS)) begin
                  state_d = S_REPEAT;
                  rep_d   = '0;
                  act     = 1'b1;
               end
            end
         end
         S_REPEAT: begin
            if (!held_lvl) begin
               state_d = S_IDLE;
               hold_d  = '0;
               rep_d   = '0;
            end else if (tick) begin
               rep_d = rep_q + 1'b1;
               if (rep_d == REP_W'(REP_TICKS)) begin
                  rep_d = '0;
                  act   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (act) begin
         evt_d = 1'b1;
         case (act_key)
            K_UP:    cnt_d = cnt_q + 1'b1;
            K_DN:    cnt_d = cnt_q - 1'b1;
            default: cnt_d = '0;
         endcase
      end
   end

   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         key_q   <= K_UP;
         hold_q  <= '0;
         rep_q   <= '0;
         cnt_q   <= '0;
         evt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         hold_q  <= hold_d;
         rep_q   <= rep_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
      end
   end

   assign counter = cnt_q;
   assign evt     = evt_q;
   assign led     = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_counter_ctrl.sv
// Scenario bench for key_counter_ctrl: expected counter values are queued as
// keys are pressed and popped by a monitor on every evt pulse.
module tb_key_counter_ctrl;

   logic       MHz = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_up = 1'b0, key_dn = 1'b0, key_clr = 1'b0;
   logic [2:0] counter;
   logic       evt, led, tick;

   int unsigned pass_cnt = 0, chk_cnt = 0;
   int unsigned cyc = 0;
   logic [2:0]  exp_q[$];
   int unsigned evt_cyc[$];
   logic [2:0]  exp_cnt = '0;
   logic [2:0]  mon_e;

   key_counter_ctrl #(
      .DIV(4), .DEB_LEN(3), .CNT_W(3), .HOLD_TICKS(5), .REP_TICKS(2)
   ) dut (
      .MHz(MHz), .rst_n(rst_n), .key_up(key_up), .key_dn(key_dn),
      .key_clr(key_clr), .counter(counter), .evt(evt), .led(led), .tick(tick)
   );

   always #5 MHz = ~MHz;
   always @(posedge MHz) cyc++;

   always @(negedge MHz) begin
      if (rst_n && evt) begin
         evt_cyc.push_back(cyc);
         chk_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL evt_unexpected: counter=%0d, no update expected", counter);
         end else begin
            mon_e = exp_q.pop_front();
            if (counter !== mon_e)
               $display("FAIL evt_counter: got %0d, expected %0d", counter, mon_e);
            else
               pass_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_key(input int k, input logic v);
      case (k)
         0:       key_up  = v;
         1:       key_dn  = v;
         default: key_clr = v;
      endcase
   endtask

   task automatic wait_evts(input int unsigned n, input int unsigned budget, input string name);
      int unsigned t = 0;
      while (evt_cyc.size() < n && t < budget) begin
         @(negedge MHz); #1;
         t++;
      end
      chk_cnt++;
      if (evt_cyc.size() < n)
         $display("FAIL %s_timeout: got %0d evts, expected %0d", name, evt_cyc.size(), n);
      else
         pass_cnt++;
   endtask

   task automatic idle_cycles(input int unsigned n);
      repeat (n) @(negedge MHz);
      #1;
   endtask

   // One press released straight after acceptance: exactly one step expected.
   task automatic press_once(input int k, input string name);
      int unsigned n0 = evt_cyc.size();
      case (k)
         0:       exp_cnt = exp_cnt + 3'd1;
         1:       exp_cnt = exp_cnt - 3'd1;
         default: exp_cnt = 3'd0;
      endcase
      exp_q.push_back(exp_cnt);
      @(negedge MHz);
      set_key(k, 1'b1);
      wait_evts(n0 + 1, 40, name);
      chk_cnt++;
      if (led !== 1'b1) $display("FAIL %s_led_on: got %b, expected 1", name, led);
      else pass_cnt++;
      set_key(k, 1'b0);
      idle_cycles(30);
      chk_cnt++;
      if (led !== 1'b0 || evt_cyc.size() != n0 + 1)
         $display("FAIL %s_release: led=%b evts=%0d, expected led=0 evts=%0d",
                  name, led, evt_cyc.size() - n0, 1);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      idle_cycles(3);
      chk_cnt++;
      if ({counter, evt, led, tick} !== 6'b0)
         $display("FAIL reset_outputs: got cnt=%0d evt=%b led=%b tick=%b, expected all 0",
                  counter, evt, led, tick);
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      int unsigned ticks = 0, bad_gap = 0, bad_out = 0, last = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge MHz); #1;
         if (counter !== 3'd0 || evt !== 1'b0 || led !== 1'b0) bad_out++;
         if (tick === 1'b1) begin
            if (ticks > 0 && cyc - last != 4) bad_gap++;
            last = cyc;
            ticks++;
         end
      end
      chk_cnt++;
      if (ticks != 25) $display("FAIL idle_tick_count: got %0d, expected 25", ticks);
      else pass_cnt++;
      chk_cnt++;
      if (bad_gap != 0) $display("FAIL idle_tick_period: got %0d bad gaps, expected 0", bad_gap);
      else pass_cnt++;
      chk_cnt++;
      if (bad_out != 0) $display("FAIL idle_outputs: got %0d nonzero samples, expected 0", bad_out);
      else pass_cnt++;
   endtask

   task automatic test_single_press();
      press_once(0, "single_up");
      chk_cnt++;
      if (counter !== 3'd1) $display("FAIL single_up_value: got %0d, expected 1", counter);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      press_once(2, "wrap_clr");
      press_once(1, "wrap_dn_0_to_7");
      press_once(0, "wrap_up_7_to_0");
      press_once(1, "wrap_dn_again");
   endtask

   // Release is issued just after the 8th step (a tick edge); the key still
   // reads pressed for 3 more ticks, so one further step lands 2 ticks later.
   task automatic test_repeat();
      int unsigned n0 = evt_cyc.size();
      int unsigned bad = 0;
      for (int i = 0; i < 9; i++) begin
         exp_cnt = exp_cnt + 3'd1;
         exp_q.push_back(exp_cnt);
      end
      @(negedge MHz);
      key_up = 1'b1;
      wait_evts(n0 + 8, 200, "repeat_hold");
      key_up = 1'b0;
      wait_evts(n0 + 9, 30, "repeat_tail");
      idle_cycles(30);
      chk_cnt++;
      if (evt_cyc.size() != n0 + 9 || led !== 1'b0)
         $display("FAIL repeat_steps: got %0d evts led=%b, expected 9 led=0", evt_cyc.size() - n0, led);
      else pass_cnt++;
      if (evt_cyc.size() >= n0 + 9) begin
         chk_cnt++;
         if (evt_cyc[n0+1] - evt_cyc[n0] != 19)
            $display("FAIL repeat_first_gap: got %0d cycles, expected 19", evt_cyc[n0+1] - evt_cyc[n0]);
         else pass_cnt++;
         for (int i = 2; i < 9; i++)
            if (evt_cyc[n0+i] - evt_cyc[n0+i-1] != 8) bad++;
         chk_cnt++;
         if (bad != 0) $display("FAIL repeat_period: got %0d bad gaps, expected 0", bad);
         else pass_cnt++;
      end
   endtask

   task automatic test_priority();
      int unsigned n0;
      for (int i = 0; i < 5; i++) press_once(0, "prio_setup");
      n0 = evt_cyc.size();
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      exp_cnt = 3'd1;
      @(negedge MHz);
      key_up  = 1'b1;
      key_clr = 1'b1;
      wait_evts(n0 + 1, 40, "prio_clr");
      key_clr = 1'b0;
      wait_evts(n0 + 2, 40, "prio_up_after_clr");
      key_up = 1'b0;
      idle_cycles(30);
      chk_cnt++;
      if (evt_cyc.size() != n0 + 2)
         $display("FAIL prio_evt_count: got %0d, expected 2", evt_cyc.size() - n0);
      else pass_cnt++;
      if (evt_cyc.size() >= n0 + 2) begin
         chk_cnt++;
         if (evt_cyc[n0+1] - evt_cyc[n0] != 13)
            $display("FAIL prio_handover_gap: got %0d cycles, expected 13", evt_cyc[n0+1] - evt_cyc[n0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_glitch_reset();
      int unsigned n0 = evt_cyc.size();
      int unsigned c0;
      @(negedge MHz);
      key_dn = 1'b1;
      repeat (8) @(negedge MHz);
      key_dn = 1'b0;
      idle_cycles(40);
      chk_cnt++;
      if (evt_cyc.size() != n0) $display("FAIL glitch_ignored: got %0d evts, expected 0", evt_cyc.size() - n0);
      else pass_cnt++;

      exp_q.push_back(3'd0);
      exp_q.push_back(3'd7);
      @(negedge MHz);
      key_dn = 1'b1;
      wait_evts(n0 + 2, 100, "rst_dn_repeat");
      idle_cycles(2);
      chk_cnt++;
      if (led !== 1'b1) $display("FAIL rst_pre_led: got %b, expected 1", led);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({counter, evt, led, tick} !== 6'b0)
         $display("FAIL rst_midpress: got cnt=%0d evt=%b led=%b tick=%b, expected all 0",
                  counter, evt, led, tick);
      else pass_cnt++;
      exp_q.delete();
      idle_cycles(3);
      n0 = evt_cyc.size();
      exp_q.push_back(3'd7);
      @(negedge MHz);
      rst_n = 1'b1;
      c0 = cyc;
      wait_evts(n0 + 1, 40, "rst_redebounce");
      key_dn = 1'b0;
      if (evt_cyc.size() >= n0 + 1) begin
         chk_cnt++;
         if (evt_cyc[n0] - c0 != 13)
            $display("FAIL rst_redebounce_latency: got %0d cycles, expected 13", evt_cyc[n0] - c0);
         else pass_cnt++;
      end
      idle_cycles(30);
      chk_cnt++;
      if (evt_cyc.size() != n0 + 1 || counter !== 3'd7)
         $display("FAIL rst_final: got evts=%0d cnt=%0d, expected evts=1 cnt=7",
                  evt_cyc.size() - n0, counter);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_press();
      test_wrap();
      test_repeat();
      test_priority();
      test_glitch_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
